// File: rtl/expr_tx.sv
// Serialises a BCD sum-of-products expression as ASCII: digit (op digit)* then a 00 terminator.
// Define EXPR_TX_EVAL_EN to also evaluate the expression ('*' before '+') into result.
module expr_tx (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [2:0]  len,
    input  logic [31:0] digits,
    input  logic [6:0]  ops,
    output logic [7:0]  out,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        OP   = 2'd2,
        TERM = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  k;
    logic [2:0]  len_q;
    logic [31:0] digits_q;
    logic [7:0]  ops_q;
    logic        err_q;
    logic        bad;
    logic        accept;
    logic [3:0]  cur_dig;

    // Only operands 0..len are screened; higher nibbles are don't-care.
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((i <= int'(len)) && (digits[4*i +: 4] > 4'd9))
                bad = 1'b1;
        end
    end

    assign accept  = (state == IDLE) && start && !bad;
    assign cur_dig = digits_q[4*k +: 4];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            k        <= 3'd0;
            len_q    <= 3'd0;
            digits_q <= 32'd0;
            ops_q    <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == IDLE) && start && bad;
            if (accept) begin
                k        <= 3'd0;
                len_q    <= len;
                digits_q <= digits;
                ops_q    <= {1'b0, ops};
            end else if (state == OP) begin
                k <= k + 3'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        out      = 8'h00;
        valid    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = DIG;
            DIG: begin
                out      = 8'h30 + {4'h0, cur_dig};
                valid    = 1'b1;
                state_nx = (k < len_q) ? OP : TERM;
            end
            OP: begin
                out      = ops_q[k] ? 8'h2A : 8'h2B;
                valid    = 1'b1;
                state_nx = DIG;
            end
            TERM: begin
                valid    = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign err  = err_q;

`ifdef EXPR_TX_EVAL_EN
    logic [15:0] sum, prod, res;
    logic [3:0]  nxt_dig;
    logic [2:0]  k_nx;

    assign k_nx    = k + 3'd1;
    assign nxt_dig = digits_q[4*k_nx +: 4];

    // prod carries the running product term; it folds into sum on each '+'.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum  <= 16'd0;
            prod <= 16'd0;
            res  <= 16'd0;
        end else if (accept) begin
            sum  <= 16'd0;
            prod <= {12'd0, digits[3:0]};
        end else if (state == OP) begin
            if (ops_q[k]) begin
                prod <= prod * {12'd0, nxt_dig};
            end else begin
                sum  <= sum + prod;
                prod <= {12'd0, nxt_dig};
            end
        end else if ((state == DIG) && (k == len_q)) begin
            res <= sum + prod;
        end
    end

    assign result = res;
`else
    assign result = 16'h0000;
`endif

endmodule

// File: tb/tb_expr_tx.sv
// Directed bench for expr_tx: expected characters are queued at each accepted start
// and popped as the DUT emits them; evaluation checks follow EXPR_TX_EVAL_EN.
module tb_expr_tx;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [2:0]  len;
    logic [31:0] digits;
    logic [6:0]  ops;
    logic [7:0]  out;
    logic        valid, busy, done, err;
    logic [15:0] result;

    int total = 0;
    int bad = 0;
    logic [8:0]  q[$];
    logic        exp_err = 1'b0;
    logic [15:0] exp_res = 16'h0000;

    expr_tx dut (
        .clk(clk), .clr(clr), .start(start), .len(len), .digits(digits), .ops(ops),
        .out(out), .valid(valid), .busy(busy), .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check();
        logic       ev;
        logic [8:0] e;
        ev = (q.size() != 0);
        chk("valid", {31'd0, valid}, {31'd0, ev});
        chk("busy", {31'd0, busy}, {31'd0, ev});
        if (ev) begin
            e = q.pop_front();
            chk("out", {24'd0, out}, {24'd0, e[7:0]});
            chk("done", {31'd0, done}, {31'd0, e[8]});
            if (e[8]) chk("result", {16'd0, result}, {16'd0, exp_res});
        end else begin
            chk("out_idle", {24'd0, out}, 32'd0);
            chk("done_idle", {31'd0, done}, 32'd0);
        end
        chk("err", {31'd0, err}, {31'd0, exp_err});
        exp_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check();
    endtask

    // Drive an accepted-or-rejected start from IDLE and queue what should follow.
    task automatic send(input logic [2:0] l, input logic [31:0] d, input logic [6:0] o);
        logic        is_bad;
        logic [15:0] s, p, nv;
        len = l; digits = d; ops = o; start = 1'b1;
        is_bad = 1'b0;
        for (int i = 0; i <= int'(l); i++)
            if (d[4*i +: 4] > 4'd9) is_bad = 1'b1;
        if (is_bad) begin
            exp_err = 1'b1;
        end else begin
            s = 16'd0;
            p = {12'd0, d[3:0]};
            for (int i = 0; i <= int'(l); i++) begin
                q.push_back({1'b0, 8'h30 + {4'h0, d[4*i +: 4]}});
                if (i < int'(l)) begin
                    q.push_back({1'b0, o[i] ? 8'h2A : 8'h2B});
                    nv = {12'd0, d[4*(i+1) +: 4]};
                    if (o[i]) p = p * nv;
                    else begin s = s + p; p = nv; end
                end
            end
            q.push_back({1'b1, 8'h00});
`ifdef EXPR_TX_EVAL_EN
            exp_res = s + p;
`else
            exp_res = 16'h0000;
`endif
        end
        tick();
        start = 1'b0;
        digits = $urandom; ops = 7'($urandom); len = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        chk("frame_timeout", q.size(), 32'd0);
        tick();
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; len = 3'd0; digits = 32'd0; ops = 7'd0;
        #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        tick();

        send(3'd2, 32'h00000321, 7'b0000010);
        drain();
        send(3'd0, 32'h00000005, 7'd0);
        drain();
        chk("result_hold", {16'd0, result}, {16'd0, exp_res});

        send(3'd1, 32'h000000A4, 7'd0);
        tick();
        send(3'd0, 32'h0000004A, 7'd0);
        tick();
        send(3'd0, 32'hFFFFFFF9, 7'd0);
        drain();

        send(3'd3, 32'h00008765, 7'b0000101);
        tick();
        len = 3'd1; digits = 32'h000000AA; ops = 7'h7F; start = 1'b1;
        tick();
        start = 1'b0;
        len = 3'd0; digits = 32'h00000001; start = 1'b1;
        tick();
        start = 1'b0;
        drain();

        send(3'd7, 32'h99999999, 7'h7F);
        drain();
        send(3'd6, 32'h01234567, 7'b0101010);
        drain();
        send(3'd4, 32'h00090807, 7'b0000000);
        drain();

        send(3'd3, 32'h00004321, 7'b0000011);
        tick();
        tick();
        #2 clr = 1'b1;
        #1;
        chk("clr_valid", {31'd0, valid}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_out", {24'd0, out}, 32'd0);
        chk("clr_done", {31'd0, done}, 32'd0);
        chk("clr_result", {16'd0, result}, 32'd0);
        q.delete();
        @(negedge clk);
        clr = 1'b0;
        check();
        tick();
        send(3'd2, 32'h00000888, 7'b0000001);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
